// File: rtl/lut_mul_pkg.sv
// Shared types and constants for the sequential 2-bit LUT digit multiplier.
package lut_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiplier digit values and the multiple of a each one selects
  localparam logic [1:0] LUT_ZERO = 2'b00;
  localparam logic [1:0] LUT_X1   = 2'b01;
  localparam logic [1:0] LUT_X2   = 2'b10;
  localparam logic [1:0] LUT_X3   = 2'b11;

  // Cycles from operand acceptance to out_valid: one per 2-bit digit
  function automatic int lut_mul_latency(input int b_width);
    return b_width / 2;
  endfunction

endpackage

// File: rtl/lut_mul_digit.sv
// One LUT digit stage: maps a 2-bit digit to 0, a, 2a or 3a.
module lut_mul_digit
  import lut_mul_pkg::*;
#(
  parameter int A_WIDTH = 8
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [1:0]         d,
  output logic [A_WIDTH+1:0] partial
);

  // Select the digit multiple; 3a = 2a + a fits in A_WIDTH+2 bits
  always_comb begin
    partial = '0;
    case (d)
      LUT_ZERO: partial = '0;
      LUT_X1:   partial = {2'b00, a};
      LUT_X2:   partial = {1'b0, a, 1'b0};
      LUT_X3:   partial = {1'b0, a, 1'b0} + {2'b00, a};
      default:  partial = '0;
    endcase
  end

endmodule

// File: rtl/lut_multiplier_seq.sv
// Sequential unsigned multiplier: consumes b two bits per clock through a
// LUT digit stage, with valid/ready handshakes on operands and product.
module lut_multiplier_seq
  import lut_mul_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_WIDTH+B_WIDTH-1:0] mul
);

  localparam int N     = lut_mul_latency(B_WIDTH);
  localparam int P_W   = A_WIDTH + 2;
  localparam int ACC_W = A_WIDTH + B_WIDTH + 2;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);

  if (B_WIDTH < 2 || (B_WIDTH % 2) != 0) begin : g_bad_b_width
    $error("lut_multiplier_seq: B_WIDTH must be even and >= 2");
  end
  if (A_WIDTH < 2) begin : g_bad_a_width
    $error("lut_multiplier_seq: A_WIDTH must be >= 2");
  end

  state_e                     state_q;
  logic [A_WIDTH-1:0]         a_q;
  logic [B_WIDTH-1:0]         b_q;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [A_WIDTH+B_WIDTH-1:0] mul_q;
  logic                       out_valid_q;
  logic [P_W-1:0]             partial;
  logic [P_W-1:0]             sum;

  lut_mul_digit #(.A_WIDTH(A_WIDTH)) u_digit (
    .a       (a_q),
    .d       (b_q[1:0]),
    .partial (partial)
  );

  // Ready in IDLE, or in DONE when the product is being taken this edge
  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  end

  // Add the digit multiple into the top of the accumulator, then shift the
  // whole accumulator down one digit; the upper sum never carries out
  // because the shifted-in history is always below a.
  always_comb begin
    sum   = acc_q[ACC_W-1:B_WIDTH] + partial;
    acc_d = {sum, acc_q[B_WIDTH-1:0]} >> 2;
  end

  // FSM, operand latch, digit counter and registered product/valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      // Covers both IDLE accept and the DONE->RUN back-to-back handoff
      a_q         <= a;
      b_q         <= b;
      acc_q       <= '0;
      cnt_q       <= CNT_LOAD;
      out_valid_q <= 1'b0;
      state_q     <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          acc_q <= acc_d;
          b_q   <= b_q >> 2;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            mul_q       <= acc_d[A_WIDTH+B_WIDTH-1:0];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // The two accumulator guard bits dropped from mul must be zero
  a_acc_guard_zero: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q != DONE) || (acc_q[ACC_W-1 -: 2] == 2'b00));

  assign mul       = mul_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// Directed bench for lut_multiplier_seq: handshake timing, backpressure,
// back-to-back throughput, mid-run reset and a small width sweep.
module tb_lut_multiplier_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8x8 main instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] mul;

  lut_multiplier_seq #(.A_WIDTH(8), .B_WIDTH(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .mul(mul));

  // 4x2 instance
  logic       iv42, ir42, ov42, or42;
  logic [3:0] a42;
  logic [1:0] b42;
  logic [5:0] m42;

  lut_multiplier_seq #(.A_WIDTH(4), .B_WIDTH(2)) u_42 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv42), .in_ready(ir42),
    .a(a42), .b(b42), .out_valid(ov42), .out_ready(or42), .mul(m42));

  // 5x6 instance
  logic        iv56, ir56, ov56, or56;
  logic [4:0]  a56;
  logic [5:0]  b56;
  logic [10:0] m56;

  lut_multiplier_seq #(.A_WIDTH(5), .B_WIDTH(6)) u_56 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv56), .in_ready(ir56),
    .a(a56), .b(b56), .out_valid(ov56), .out_ready(or56), .mul(m56));

  // 16x16 instance
  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] m16;

  lut_multiplier_seq #(.A_WIDTH(16), .B_WIDTH(16)) u_16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .mul(m16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 1; a = '0; b = '0;
    iv42 = 0; or42 = 1; a42 = '0; b42 = '0;
    iv56 = 0; or56 = 1; a56 = '0; b56 = '0;
    iv16 = 0; or16 = 1; a16 = '0; b16 = '0;
    reset_n = 0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (mul !== 16'h0000) begin errors++; $display("FAIL reset_mul got %h want 0000", mul); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    reset_n = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  ta [4];
    logic [7:0]  tb [4];
    logic [15:0] te [4];
    int lat;
    ta[0] = 8'h0F; tb[0] = 8'h03; te[0] = 16'h002D;
    ta[1] = 8'hFF; tb[1] = 8'hFF; te[1] = 16'hFE01;
    ta[2] = 8'h00; tb[2] = 8'hAA; te[2] = 16'h0000;
    ta[3] = 8'h01; tb[3] = 8'h80; te[3] = 16'h0080;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      a = ta[k]; b = tb[k]; in_valid = 1;
      tick();
      in_valid = 0; a = 8'h55; b = 8'h55;  // operands may change after accept
      lat = 0;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 4", k, lat); end
      checks++;
      if (mul !== te[k]) begin errors++; $display("FAIL basic_mul[%0d] got %h want %h", k, mul, te[k]); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse[%0d] out_valid got %0b want 0", k, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 0;
    a = 8'h12; b = 8'h34; in_valid = 1;
    tick();
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    // Offer new operands while stalled; they must be ignored
    a = 8'hFF; b = 8'hFF; in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (mul !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] mul=%h ov=%0b ir=%0b want 03a8/1/0", c, mul, out_valid, in_ready);
      end
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follow got %0b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || mul !== 16'h03A8) begin
      errors++; $display("FAIL bp_release ov=%0b mul=%h want 0/03a8", out_valid, mul);
    end
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ignored_op ov=%0b ir=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pa [3];
    logic [7:0]  pb [3];
    logic [15:0] pe [3];
    int sent, got, cyc, last;
    logic acc_now;
    pa[0] = 8'h03; pb[0] = 8'h04; pe[0] = 16'h000C;
    pa[1] = 8'h10; pb[1] = 8'h10; pe[1] = 16'h0100;
    pa[2] = 8'hAB; pb[2] = 8'hCD; pe[2] = 16'h88EF;
    out_ready = 1;
    sent = 0; got = 0; last = -1;
    a = pa[0]; b = pb[0]; in_valid = 1;
    for (cyc = 0; cyc < 40; cyc++) begin
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) begin
        sent++;
        if (sent < 3) begin a = pa[sent]; b = pb[sent]; end
        else in_valid = 0;
      end
      if (out_valid) begin
        checks++;
        if (got >= 3) begin
          errors++; $display("FAIL b2b_extra output %h", mul);
        end else if (mul !== pe[got]) begin
          errors++; $display("FAIL b2b_mul[%0d] got %h want %h", got, mul, pe[got]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 5) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 5", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
    end
    checks++;
    if (got != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    out_ready = 1;
    a = 8'hFF; b = 8'hFF; in_valid = 1;
    tick();
    in_valid = 0;
    tick();  // second cycle of RUN
    reset_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mul !== 16'h0000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid ov=%0b mul=%h ir=%0b want 0/0000/1", out_valid, mul, in_ready);
    end
    tick();
    reset_n = 1;
    tick();
    a = 8'h05; b = 8'h07; in_valid = 1;
    tick();
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 4 || mul !== 16'h0023) begin
      errors++; $display("FAIL rst_after lat=%0d mul=%h want 4/0023", lat, mul);
    end
    tick();
  endtask

  task automatic test_param_sweep();
    int lat;
    longint exp;
    // 4x2: latency 1
    for (int k = 0; k < 6; k++) begin
      a42 = 4'($urandom); b42 = 2'($urandom);
      if (k == 0) begin a42 = 4'hF; b42 = 2'h3; end
      exp = longint'(a42) * longint'(b42);
      iv42 = 1; tick(); iv42 = 0;
      lat = 0;
      while (!ov42 && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat != 1 || m42 !== 6'(exp)) begin
        errors++; $display("FAIL sweep42[%0d] lat=%0d mul=%h want 1/%h", k, lat, m42, 6'(exp));
      end
      tick();
    end
    // 5x6: latency 3
    for (int k = 0; k < 6; k++) begin
      a56 = 5'($urandom); b56 = 6'($urandom);
      if (k == 0) begin a56 = 5'h1F; b56 = 6'h3F; end
      exp = longint'(a56) * longint'(b56);
      iv56 = 1; tick(); iv56 = 0;
      lat = 0;
      while (!ov56 && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat != 3 || m56 !== 11'(exp)) begin
        errors++; $display("FAIL sweep56[%0d] lat=%0d mul=%h want 3/%h", k, lat, m56, 11'(exp));
      end
      tick();
    end
    // 16x16: latency 8
    for (int k = 0; k < 6; k++) begin
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (k == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
      exp = longint'(a16) * longint'(b16);
      iv16 = 1; tick(); iv16 = 0;
      lat = 0;
      while (!ov16 && lat < 30) begin tick(); lat++; end
      checks++;
      if (lat != 8 || m16 !== 32'(exp)) begin
        errors++; $display("FAIL sweep16[%0d] lat=%0d mul=%h want 8/%h", k, lat, m16, 32'(exp));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
